// File: rtl/endian_swapper_pkg.sv
// Shared types and CSR map for the endian swapper and the packet scheduler that drives it.
package endian_swapper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    PASS = 2'd2
  } sched_state_t;

  localparam logic [1:0]  CSR_ADDR_CTRL     = 2'd0;
  localparam logic [1:0]  CSR_ADDR_PKTCNT   = 2'd1;
  localparam int unsigned CSR_CTRL_SWAP_BIT = 0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/endian_swapper_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = k + 32'(ptr);
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/endian_swapper_sched.sv
// Packet scheduler: round-robin over sources, reprograms the swapper mode over CSR when needed,
// then forwards one whole packet into the swapper stream input.
module endian_swapper_sched
  import endian_swapper_pkg::*;
#(
  parameter  int unsigned DATA_BYTES = 8,
  parameter  int unsigned NUM_SRC    = 2,
  localparam int unsigned EW         = $clog2(DATA_BYTES),
  localparam int unsigned DW         = DATA_BYTES * 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_SRC*DW-1:0] s_data,
  input  logic [NUM_SRC*EW-1:0] s_empty,
  input  logic [NUM_SRC-1:0]    s_valid,
  input  logic [NUM_SRC-1:0]    s_sop,
  input  logic [NUM_SRC-1:0]    s_eop,
  output logic [NUM_SRC-1:0]    s_ready,
  input  logic [NUM_SRC-1:0]    src_swap,
  output logic [DW-1:0]         m_data,
  output logic [EW-1:0]         m_empty,
  output logic                  m_valid,
  output logic                  m_sop,
  output logic                  m_eop,
  input  logic                  m_ready,
  output logic [1:0]            csr_address,
  output logic                  csr_write,
  output logic [31:0]           csr_writedata,
  output logic                  csr_read,
  input  logic                  csr_waitrequest,
  output logic [NUM_SRC-1:0]    grant,
  output logic                  cur_swap,
  output logic [15:0]           cfg_count
);

  localparam int unsigned IW = $clog2(NUM_SRC);

  sched_state_t  state;
  logic [IW-1:0] sel;
  logic [IW-1:0] rr_ptr;
  logic          want;

  logic [NUM_SRC-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic               arb_want;
  logic [31:0]        sel_idx;
  logic               beat_acc;

  rr_arbiter #(
    .N (NUM_SRC)
  ) u_arb (
    .req (s_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign arb_want = |(arb_gnt & src_swap);
  assign sel_idx  = 32'(sel);
  assign beat_acc = (state == PASS) && s_valid[sel] && m_ready;
  assign csr_read = 1'b0;

  // Stream mux is combinational so the selected source sees m_ready in the same cycle.
  always_comb begin
    m_data  = s_data[sel_idx*DW +: DW];
    m_empty = s_empty[sel_idx*EW +: EW];
    m_sop   = s_sop[sel];
    m_eop   = s_eop[sel];
    m_valid = 1'b0;
    s_ready = '0;
    grant   = '0;
    if (state == PASS) begin
      m_valid      = s_valid[sel];
      s_ready[sel] = m_ready;
      grant[sel]   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      sel           <= '0;
      want          <= 1'b0;
      rr_ptr        <= '0;
      cur_swap      <= 1'b0;
      cfg_count     <= '0;
      csr_write     <= 1'b0;
      csr_address   <= CSR_ADDR_CTRL;
      csr_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            sel  <= arb_idx;
            want <= arb_want;
            if (arb_want != cur_swap) begin
              state         <= CFG;
              csr_write     <= 1'b1;
              csr_address   <= CSR_ADDR_CTRL;
              csr_writedata <= 32'(arb_want) << CSR_CTRL_SWAP_BIT;
            end else begin
              state <= PASS;
            end
          end
        end
        CFG: begin
          // Waitrequest also covers the swapper draining its in-flight packet.
          if (!csr_waitrequest) begin
            csr_write     <= 1'b0;
            csr_writedata <= '0;
            cur_swap      <= want;
            cfg_count     <= sat_inc16(cfg_count);
            state         <= PASS;
          end
        end
        PASS: begin
          if (beat_acc && s_eop[sel]) begin
            state  <= IDLE;
            rr_ptr <= (sel_idx == NUM_SRC - 1) ? '0 : sel + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_endian_swapper_sched.sv
// Bench for endian_swapper_sched: packet-level scoreboard model plus directed scenarios.
module tb_endian_swapper_sched;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  empty;
    logic        sop;
    logic        eop;
  } beat_t;

  logic         clk;
  logic         reset_n;
  logic [127:0] s_data;
  logic [5:0]   s_empty;
  logic [1:0]   s_valid, s_sop, s_eop, s_ready, src_swap, grant;
  logic [63:0]  m_data;
  logic [2:0]   m_empty;
  logic         m_valid, m_sop, m_eop, m_ready;
  logic [1:0]   csr_address;
  logic         csr_write, csr_read, csr_waitrequest, cur_swap;
  logic [31:0]  csr_writedata;
  logic [15:0]  cfg_count;

  endian_swapper_sched #(
    .DATA_BYTES (8),
    .NUM_SRC    (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .s_data          (s_data),
    .s_empty         (s_empty),
    .s_valid         (s_valid),
    .s_sop           (s_sop),
    .s_eop           (s_eop),
    .s_ready         (s_ready),
    .src_swap        (src_swap),
    .m_data          (m_data),
    .m_empty         (m_empty),
    .m_valid         (m_valid),
    .m_sop           (m_sop),
    .m_eop           (m_eop),
    .m_ready         (m_ready),
    .csr_address     (csr_address),
    .csr_write       (csr_write),
    .csr_writedata   (csr_writedata),
    .csr_read        (csr_read),
    .csr_waitrequest (csr_waitrequest),
    .grant           (grant),
    .cur_swap        (cur_swap),
    .cfg_count       (cfg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  beat_t drv_q[2][$];
  beat_t exp_q[2][$];

  // Packet-level model state
  int   m_owner = -1;
  int   m_ptr = 0;
  logic m_want = 1'b0;
  logic m_cur = 1'b0;
  int   m_cfg = 0;
  logic m_need_cfg = 1'b0;

  int csr_cycles, csr_xfers, beats_acc;
  int pkt_log[$];

  int         mready_mode = 0;
  int         mready_low = 0;
  int         wr_hold = 0;
  bit         flip_pending = 0;
  logic [1:0] flip_val = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int src, input int nbeats, input int tag);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.data  = 64'hA500_0000_0000_0000 | (64'(src) << 48) | (64'(tag) << 16) | 64'(k);
      b.sop   = (k == 0);
      b.eop   = (k == nbeats - 1);
      b.empty = b.eop ? 3'(tag + src) : 3'd0;
      drv_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
  endtask

  task automatic clear_stats();
    csr_cycles = 0;
    csr_xfers  = 0;
    beats_acc  = 0;
    pkt_log.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (drv_q[i].size() > 0) begin
        s_valid[i]          = 1'b1;
        s_data[i*64 +: 64]  = drv_q[i][0].data;
        s_empty[i*3 +: 3]   = drv_q[i][0].empty;
        s_sop[i]            = drv_q[i][0].sop;
        s_eop[i]            = drv_q[i][0].eop;
      end else begin
        s_valid[i]          = 1'b0;
        s_data[i*64 +: 64]  = '0;
        s_empty[i*3 +: 3]   = '0;
        s_sop[i]            = 1'b0;
        s_eop[i]            = 1'b0;
      end
    end
    if (mready_low > 0) begin
      m_ready = 1'b0;
      mready_low--;
    end else begin
      m_ready = (mready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    csr_waitrequest = (wr_hold > 0);
  endtask

  task automatic sample();
    beat_t e;
    int    o;
    if (m_owner < 0 && (csr_write || m_valid)) begin
      for (int k = 0; k < 2; k++) begin
        o = (m_ptr + k) % 2;
        if (m_owner < 0 && exp_q[o].size() > 0) m_owner = o;
      end
      if (m_owner < 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_output: got csr_write=%0b m_valid=%0b expected none", csr_write,
                 m_valid);
      end else begin
        m_want     = src_swap[m_owner];
        m_need_cfg = (m_want != m_cur);
        pkt_log.push_back(m_owner);
      end
    end
    chk("cur_swap", 64'(cur_swap), 64'(m_cur));
    chk("cfg_count", 64'(cfg_count), 64'(m_cfg));
    if (csr_write) begin
      csr_cycles++;
      chk("csr_write_needed", 64'(csr_write), 64'(m_need_cfg));
      chk("csr_address", 64'(csr_address), 64'(0));
      chk("csr_writedata", 64'(csr_writedata), 64'({31'b0, m_want}));
      if (!csr_waitrequest) begin
        csr_xfers++;
        m_cur      = m_want;
        m_cfg++;
        m_need_cfg = 1'b0;
      end else if (wr_hold > 0) begin
        wr_hold--;
      end
    end
    if (m_valid && m_owner >= 0) begin
      e = exp_q[m_owner][0];
      chk("cfg_before_beat", 64'(m_need_cfg), 64'(0));
      chk("grant", 64'(grant), 64'(1) << m_owner);
      chk("s_ready_other", 64'(s_ready[1-m_owner]), 64'(0));
      chk("m_data", m_data, e.data);
      chk("m_empty", 64'(m_empty), 64'(e.empty));
      chk("m_sop_eop", 64'({m_sop, m_eop}), 64'({e.sop, e.eop}));
      if (m_ready) begin
        beats_acc++;
        void'(exp_q[m_owner].pop_front());
        if (flip_pending) begin
          src_swap     = flip_val;
          flip_pending = 0;
        end
        if (e.eop) begin
          m_ptr   = (m_owner + 1) % 2;
          m_owner = -1;
        end
      end
    end
    for (int i = 0; i < 2; i++)
      if (s_valid[i] && s_ready[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #4;
    sample();
    @(posedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q[0].size() > 0 || exp_q[1].size() > 0 || m_owner >= 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0",
               exp_q[0].size() + exp_q[1].size());
    end
    repeat (2) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_csr_write", 64'(csr_write), 64'(0));
    chk("rst_cur_swap", 64'(cur_swap), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_cfg_count", 64'(cfg_count), 64'(0));
    for (int i = 0; i < 2; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
    m_owner = -1; m_ptr = 0; m_cur = 1'b0; m_cfg = 0; m_need_cfg = 1'b0;
    wr_hold = 0; mready_low = 0; flip_pending = 0;
    s_valid = '0;
    csr_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rep;
    reset_n = 1'b0;
    s_data = '0; s_empty = '0; s_valid = '0; s_sop = '0; s_eop = '0;
    src_swap = 2'b00; m_ready = 1'b1; csr_waitrequest = 1'b0;
    clear_stats();
    #12;
    chk("init_grant", 64'(grant), 64'(0));
    chk("init_csr_write", 64'(csr_write), 64'(0));
    chk("init_csr_data", 64'(csr_writedata), 64'(0));
    chk("init_csr_addr", 64'(csr_address), 64'(0));
    chk("init_cfg_count", 64'(cfg_count), 64'(0));
    chk("init_m_valid", 64'(m_valid), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // 1: same mode, single 3-beat packet, no CSR traffic
    push_pkt(0, 3, 1);
    drain(200);
    chk("t1_cfg_count", 64'(cfg_count), 64'(0));
    chk("t1_csr_cycles", 64'(csr_cycles), 64'(0));
    chk("t1_beats", 64'(beats_acc), 64'(3));

    // 2: src1 needs swap; src0 goes first, then one CSR write of 1
    do_reset();
    clear_stats();
    src_swap = 2'b10;
    push_pkt(0, 2, 2);
    push_pkt(1, 2, 3);
    drain(200);
    chk("t2_cfg_count", 64'(cfg_count), 64'(1));
    chk("t2_cur_swap", 64'(cur_swap), 64'(1));
    chk("t2_csr_xfers", 64'(csr_xfers), 64'(1));
    chk("t2_csr_cycles", 64'(csr_cycles), 64'(1));
    chk("t2_first_owner", 64'(pkt_log[0]), 64'(0));
    chk("t2_second_owner", 64'(pkt_log[1]), 64'(1));

    // 3: CSR write stretched by 5 waitrequest cycles
    clear_stats();
    src_swap = 2'b00;
    wr_hold = 5;
    push_pkt(0, 2, 4);
    drain(200);
    chk("t3_csr_cycles", 64'(csr_cycles), 64'(6));
    chk("t3_cfg_count", 64'(cfg_count), 64'(2));
    chk("t3_cur_swap", 64'(cur_swap), 64'(0));

    // 4: both sources back-to-back, random m_ready
    clear_stats();
    mready_mode = 1;
    for (int p = 0; p < 4; p++) begin
      push_pkt(0, 1 + (p % 3), 10 + p);
      push_pkt(1, 2 + (p % 2), 20 + p);
    end
    drain(2000);
    mready_mode = 0;
    rep = 0;
    for (int k = 1; k < pkt_log.size(); k++) if (pkt_log[k] == pkt_log[k-1]) rep++;
    chk("t4_pkts", 64'(pkt_log.size()), 64'(8));
    chk("t4_repeats", 64'(rep), 64'(0));
    chk("t4_beats", 64'(beats_acc), 64'(17));
    chk("t4_csr_cycles", 64'(csr_cycles), 64'(0));

    // 5: single-beat packet stalled by m_ready
    clear_stats();
    mready_low = 3;
    push_pkt(0, 1, 30);
    drain(200);
    chk("t5_beats", 64'(beats_acc), 64'(1));
    #1;
    chk("t5_idle_grant", 64'(grant), 64'(0));

    // src_swap change mid-packet applies only to the next packet
    clear_stats();
    flip_pending = 1;
    flip_val = 2'b01;
    push_pkt(0, 4, 40);
    drain(200);
    chk("t5b_no_cfg", 64'(csr_cycles), 64'(0));
    push_pkt(0, 1, 41);
    drain(200);
    chk("t5b_cfg_next", 64'(csr_xfers), 64'(1));
    chk("t5b_cur_swap", 64'(cur_swap), 64'(1));

    // 6: reset mid-PASS, then mid-CFG, then arbitration restarts at src0
    push_pkt(0, 6, 50);
    repeat (4) cycle();
    #1;
    chk("t6_in_pass", 64'(grant), 64'(1));
    do_reset();
    src_swap = 2'b01;
    wr_hold = 1000;
    push_pkt(0, 2, 60);
    repeat (3) cycle();
    #1;
    chk("t6_in_cfg", 64'(csr_write), 64'(1));
    do_reset();
    clear_stats();
    src_swap = 2'b00;
    push_pkt(1, 1, 70);
    push_pkt(0, 1, 71);
    drain(200);
    chk("t6_first_after_reset", 64'(pkt_log[0]), 64'(0));
    chk("t6_beats", 64'(beats_acc), 64'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
